// File: rtl/movegen_sequencer.sv
// movegen_sequencer: drives the move-generator command port to enumerate every
// move of a position in MVV-LVA order, and forwards host board-setup commands
// onto the same port while idle.
// Optional feature: define MOVEGEN_CNT_EN to add the move_count[7:0] output.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | host commands forwarded; waiting for start
// S_ENALL  | issue EN_ALL (re-enable every square)
// S_REMASK | scan k=0..63, issue SET_EN(k,0) for each exhausted victim
// S_FINDV  | issue FIND_V
// S_WAITV  | count down the response latency, then sample the victim
// S_FINDA  | issue FIND_A on the current victim
// S_WAITA  | count down the response latency, then sample the aggressor
// S_EMIT   | present (aggressor, victim) on the move stream until accepted
// S_DISA   | issue SET_EN(aggressor,0) so the next FIND_A skips it
// S_DONE   | pulse done, drop busy
module movegen_sequencer #(
  parameter int RESP_LAT = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_data,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  input  logic [7:0] resp,
  output logic       mv_valid,
  input  logic       mv_ready,
  output logic [5:0] mv_from,
  output logic [5:0] mv_to
`ifdef MOVEGEN_CNT_EN
  ,
  output logic [7:0] move_count
`endif
);

  localparam int CNT_W = $clog2(RESP_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RESP_LAT);

  typedef enum logic [3:0] {
    S_IDLE, S_ENALL, S_REMASK, S_FINDV, S_WAITV,
    S_FINDA, S_WAITA, S_EMIT, S_DISA, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      mask_q, mask_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic             host_ready_q, host_ready_d;
  logic [7:0]       cmd_addr_q, cmd_addr_d;
  logic [7:0]       cmd_data_q, cmd_data_d;
  logic             mv_valid_q, mv_valid_d;
  logic [5:0]       mv_from_q, mv_from_d;
  logic [5:0]       mv_to_q, mv_to_d;

  // Next-state and registered-output computation; mv_to_q doubles as the
  // current victim and mv_from_q as the current aggressor.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    illegal_d  = illegal_q;
    cmd_addr_d = 8'h00;
    cmd_data_d = 8'h00;
    mv_valid_d = mv_valid_q;
    mv_from_d  = mv_from_q;
    mv_to_d    = mv_to_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          mask_d    = '0;
          illegal_d = 1'b0;
          state_d   = S_ENALL;
        end else if (host_valid && host_ready_q) begin
          cmd_addr_d = host_addr;
          cmd_data_d = host_data;
        end
      end
      S_ENALL: begin
        cmd_addr_d = 8'hC0;
        k_d        = 6'd0;
        state_d    = S_REMASK;
      end
      S_REMASK: begin
        if (mask_q[k_q]) begin
          cmd_addr_d = {6'b110100, k_q[5:4]};
          cmd_data_d = {k_q[3:0], 3'b000, 1'b0};
        end
        if (k_q == 6'd63) state_d = S_FINDV;
        else              k_d = k_q + 6'd1;
      end
      S_FINDV: begin
        cmd_addr_d = 8'hE0;
        cnt_d      = LAT_LOAD;
        state_d    = S_WAITV;
      end
      S_WAITV: begin
        if (cnt_q == '0) begin
          if (resp[7]) begin
            illegal_d = 1'b1;
            state_d   = S_DONE;
          end else if (resp[6]) begin
            state_d = S_DONE;
          end else begin
            mv_to_d = resp[5:0];
            state_d = S_FINDA;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FINDA: begin
        cmd_addr_d = {6'b111100, mv_to_q[5:4]};
        cmd_data_d = {mv_to_q[3:0], 4'h0};
        cnt_d      = LAT_LOAD;
        state_d    = S_WAITA;
      end
      S_WAITA: begin
        if (cnt_q == '0) begin
          if (resp[6]) begin
            mask_d[mv_to_q] = 1'b1;
            state_d         = S_ENALL;
          end else begin
            mv_from_d  = resp[5:0];
            mv_valid_d = 1'b1;
            state_d    = S_EMIT;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EMIT: begin
        if (mv_ready) begin
          mv_valid_d = 1'b0;
          state_d    = S_DISA;
        end
      end
      S_DISA: begin
        cmd_addr_d = {6'b110100, mv_from_q[5:4]};
        cmd_data_d = {mv_from_q[3:0], 3'b000, 1'b0};
        state_d    = S_FINDA;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    host_ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      cnt_q        <= '0;
      mask_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      host_ready_q <= 1'b0;
      cmd_addr_q   <= 8'h00;
      cmd_data_q   <= 8'h00;
      mv_valid_q   <= 1'b0;
      mv_from_q    <= '0;
      mv_to_q      <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      host_ready_q <= host_ready_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_data_q   <= cmd_data_d;
      mv_valid_q   <= mv_valid_d;
      mv_from_q    <= mv_from_d;
      mv_to_q      <= mv_to_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign illegal    = illegal_q;
  assign host_ready = host_ready_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_data   = cmd_data_q;
  assign mv_valid   = mv_valid_q;
  assign mv_from    = mv_from_q;
  assign mv_to      = mv_to_q;

`ifdef MOVEGEN_CNT_EN
  logic [7:0] move_count_q, move_count_d;

  // Accepted-move counter: cleared on start, saturating at 255.
  always_comb begin
    move_count_d = move_count_q;
    if (state_q == S_IDLE && start)
      move_count_d = 8'h00;
    else if (mv_valid_q && mv_ready && move_count_q != 8'hFF)
      move_count_d = move_count_q + 8'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) move_count_q <= 8'h00;
    else        move_count_q <= move_count_d;
  end

  assign move_count = move_count_q;
`endif

endmodule

// File: tb/tb_movegen_sequencer.sv
// Bench for movegen_sequencer: a move-list engine model answers the command
// port, and the expected move stream is the MVV-LVA sort of the move list.
`timescale 1ns/1ps
module tb_movegen_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy, done, illegal;
  logic       host_valid, host_ready;
  logic [7:0] host_addr, host_data;
  logic [7:0] cmd_addr, cmd_data;
  logic [7:0] resp;
  logic       mv_valid, mv_ready;
  logic [5:0] mv_from, mv_to;
`ifdef MOVEGEN_CNT_EN
  logic [7:0] move_count;
`endif

  movegen_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .illegal(illegal), .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_data(host_data), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .resp(resp), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_from(mv_from), .mv_to(mv_to)
`ifdef MOVEGEN_CNT_EN
    , .move_count(move_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- position / engine model ----------------
  int  n_mv;
  int  mf[32];
  int  mt[32];
  int  vval[64];
  int  aval[64];
  int  king_sq;
  bit  en[64];

  task automatic clear_pos();
    n_mv = 0;
    king_sq = -1;
    for (int i = 0; i < 64; i++) begin vval[i] = 0; aval[i] = 0; end
  endtask

  task automatic add_mv(input int f, input int t);
    mf[n_mv] = f;
    mt[n_mv] = t;
    n_mv++;
  endtask

  function automatic logic [7:0] find_v();
    int best = -1;
    bit ill = 1'b0;
    for (int i = 0; i < n_mv; i++) begin
      if (en[mf[i]] && en[mt[i]]) begin
        if (mt[i] == king_sq) ill = 1'b1;
        else if (best < 0 || vval[mt[i]] > vval[mt[best]] ||
                 (vval[mt[i]] == vval[mt[best]] && mt[i] < mt[best])) best = i;
      end
    end
    if (ill) return 8'hC0;
    if (best < 0) return 8'h40;
    return {2'b00, 6'(mt[best])};
  endfunction

  function automatic logic [7:0] find_a(input int s);
    int best = -1;
    for (int i = 0; i < n_mv; i++) begin
      if (mt[i] == s && en[mf[i]]) begin
        if (best < 0 || aval[mf[i]] < aval[mf[best]] ||
            (aval[mf[i]] == aval[mf[best]] && mf[i] < mf[best])) best = i;
      end
    end
    if (best < 0) return 8'h40;
    return {2'b00, 6'(mf[best])};
  endfunction

  int         pend_cyc = -1;
  logic [7:0] pend_val = 8'h00;
  int         seen_enall_cyc = -1;
  int         seen_findv_cyc = -1;
  int         finda_seen = 0;

  // Engine: decode the command bus each cycle.
  always @(negedge clk) begin : engine
    int s;
    s = {26'd0, cmd_addr[1:0], cmd_data[7:4]};
    if (rst_n) begin
      if (cmd_addr == 8'hC0) begin
        for (int i = 0; i < 64; i++) en[i] = 1'b1;
        if (seen_enall_cyc < 0) seen_enall_cyc = cyc;
      end else if (cmd_addr[7:2] == 6'b110100) begin
        en[s] = cmd_data[0];
      end else if (cmd_addr == 8'hE0) begin
        chk("find_overlap", cyc > pend_cyc, 1);
        pend_val = find_v();
        pend_cyc = cyc + 9;
        if (seen_findv_cyc < 0) seen_findv_cyc = cyc;
      end else if (cmd_addr[7:2] == 6'b111100) begin
        chk("find_overlap", cyc > pend_cyc, 1);
        pend_val = find_a(s);
        pend_cyc = cyc + 9;
        finda_seen++;
      end else if (cmd_addr != 8'h00) begin
        chk("host_cmd_while_busy", busy, 0);
      end
    end
  end

  // Engine response: valid only at the latency instant, noise otherwise.
  always @(posedge clk) begin
    #1;
    if (cyc == pend_cyc) resp = pend_val;
    else                 resp = 8'($urandom);
  end

  // ---------------- consumer ----------------
  int rdy_mode = 0;
  int stall_left = 0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: begin
        if (stall_left > 0) begin
          mv_ready = 1'b0;
          if (mv_valid) stall_left--;
        end else mv_ready = 1'b1;
      end
      2: mv_ready = 1'($urandom_range(0, 1));
      default: mv_ready = 1'b1;
    endcase
  end

  // ---------------- expected stream ----------------
  int exp_f[$];
  int exp_t[$];
  bit exp_illegal;
  int exp_n;

  task automatic build_expected();
    int keys[$];
    exp_f.delete();
    exp_t.delete();
    exp_illegal = 1'b0;
    for (int i = 0; i < n_mv; i++) if (mt[i] == king_sq) exp_illegal = 1'b1;
    if (!exp_illegal) begin
      for (int i = 0; i < n_mv; i++)
        keys.push_back(((15 - vval[mt[i]]) << 18) | (mt[i] << 12) | (aval[mf[i]] << 6) | mf[i]);
      keys.sort();
      foreach (keys[i]) begin
        exp_f.push_back(keys[i] & 63);
        exp_t.push_back((keys[i] >> 12) & 63);
      end
    end
    exp_n = exp_f.size();
  endtask

  // ---------------- compare process ----------------
  bit         chk_on = 1'b0;
  bit         prev_hold = 1'b0;
  logic [5:0] prev_f, prev_t;
  int         got = 0;
  int         first_f = -1;
  int         first_t = -1;

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      chk("idle_bus_zero", (cmd_addr != 8'h00) || (cmd_data == 8'h00), 1);
      chk("host_ready_vs_busy", host_ready && busy, 0);
      if (prev_hold) begin
        chk("mv_valid_held", mv_valid, 1);
        chk("mv_stable", {20'd0, mv_from, mv_to}, {20'd0, prev_f, prev_t});
      end
      if (mv_valid) begin
        chk("mv_only_busy", busy, 1);
        chk("cmd_quiet_emit", cmd_addr, 8'h00);
        if (mv_ready) begin
          got++;
          if (first_f < 0) begin first_f = mv_from; first_t = mv_to; end
          if (exp_f.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_move: got from=%0d to=%0d, expected no move", mv_from, mv_to);
          end else begin
            chk("mv_from", mv_from, exp_f.pop_front());
            chk("mv_to", mv_to, exp_t.pop_front());
          end
        end
      end
      prev_hold = mv_valid && !mv_ready;
      prev_f = mv_from;
      prev_t = mv_to;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin dc = cyc; break; end
    end
    chk("done_seen", dc >= 0, 1);
  endtask

  task automatic pulse_start(output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_checks();
    chk("illegal_flag", illegal, exp_illegal);
    chk("busy_at_done", busy, 0);
    chk("host_ready_at_done", host_ready, 1);
    chk("moves_received", got, exp_n);
    chk("moves_left", exp_f.size(), 0);
`ifdef MOVEGEN_CNT_EN
    chk("move_count", move_count, (exp_n > 255) ? 255 : exp_n);
`endif
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_pos(input int mode, input int stall);
    int t0, dc;
    build_expected();
    got = 0; first_f = -1; first_t = -1;
    rdy_mode = mode;
    stall_left = stall;
    pulse_start(t0);
    wait_done(dc);
    finish_checks();
  endtask

  task automatic pos_rook_queen();
    clear_pos();
    for (int r = 1; r < 8; r++) add_mv(0, 8 * r);
    for (int f = 1; f < 8; f++) add_mv(0, f);
    aval[0] = 5;
    vval[56] = 9;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0, dc;
    rst_n = 1'b1; start = 1'b0; host_valid = 1'b0;
    host_addr = 8'h00; host_data = 8'h00; resp = 8'h00; mv_ready = 1'b1;
    for (int i = 0; i < 64; i++) en[i] = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_host_ready", host_ready, 0);
    chk("rst_cmd_addr", cmd_addr, 8'h00);
    chk("rst_cmd_data", cmd_data, 8'h00);
    chk("rst_mv_valid", mv_valid, 0);
    chk("rst_mv_from_to", {mv_from, mv_to}, 12'h000);
    @(posedge clk); #1 rst_n = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_host_ready", host_ready, 1);

    // host command forwarded in IDLE
    @(posedge clk); #1;
    host_valid = 1'b1; host_addr = 8'hB0; host_data = 8'h45;
    @(negedge clk);
    chk("host_handshake", host_ready, 1);
    @(posedge clk); #1 host_valid = 1'b0;
    @(negedge clk);
    chk("host_fwd_addr", cmd_addr, 8'hB0);
    chk("host_fwd_data", cmd_data, 8'h45);
    @(negedge clk);
    chk("host_fwd_once", cmd_addr, 8'h00);

    // empty board; host request and a second start while busy
    clear_pos();
    build_expected();
    got = 0; rdy_mode = 0;
    seen_enall_cyc = -1; seen_findv_cyc = -1;
    pulse_start(t0);
    host_valid = 1'b1; host_addr = 8'hB0; host_data = 8'h45;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("host_stalled", host_ready, 0);
    end
    @(posedge clk); #1 host_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(dc);
    chk("empty_done_latency", dc - t0, 78);
    chk("empty_enall_offset", seen_enall_cyc - t0, 2);
    chk("empty_findv_offset", seen_findv_cyc - t0, 67);
    finish_checks();

    // rook a1 vs queen a8, free-flowing consumer
    pos_rook_queen();
    run_pos(0, 0);
    chk("rq_first_from", first_f, 0);
    chk("rq_first_to", first_t, 56);
    chk("rq_count_literal", got, 14);

    // same position, consumer stalls 20 cycles on the first move
    pos_rook_queen();
    run_pos(1, 20);
    chk("rq_stall_consumed", stall_left, 0);
    chk("rq_stall_first", {first_f[5:0], first_t[5:0]}, {6'd0, 6'd56});

    // several aggressors on one victim, random back-pressure
    clear_pos();
    aval[18] = 3; aval[3] = 9; aval[28] = 1;
    vval[35] = 5; vval[33] = 3;
    add_mv(18, 35); add_mv(3, 35); add_mv(28, 35); add_mv(18, 33);
    add_mv(18, 1);  add_mv(18, 8); add_mv(28, 36); add_mv(3, 11);
    run_pos(2, 0);
    chk("lva_first_from", first_f, 28);
    chk("lva_first_to", first_t, 35);
    chk("lva_count_literal", got, 8);

    // side not to move in check
    pos_rook_queen();
    king_sq = 56;
    run_pos(0, 0);
    chk("illegal_no_moves", got, 0);
    repeat (5) @(negedge clk);
    chk("illegal_latched", illegal, 1);
    @(posedge clk); #1 rst_n = 1'b0; chk_on = 1'b0;
    #1;
    chk("rst_clears_illegal", illegal, 0);
    @(posedge clk); #1 rst_n = 1'b1; chk_on = 1'b1;
    repeat (2) @(negedge clk);

    // reset during the FIND_A response wait
    pos_rook_queen();
    build_expected();
    got = 0; rdy_mode = 0; finda_seen = 0;
    pulse_start(t0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (finda_seen > 0) break;
    end
    chk("finda_reached", finda_seen > 0, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; chk_on = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_host_ready", host_ready, 0);
    chk("midrst_cmd", {cmd_addr, cmd_data}, 16'h0000);
    chk("midrst_mv", {19'd0, mv_valid, mv_from, mv_to}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_f.delete(); exp_t.delete();
    repeat (2) @(negedge clk);
    chk("post_rst_host_ready", host_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk_on = 1'b1;

    // enumeration still works after the mid-wait reset
    clear_pos();
    run_pos(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
